// File: rtl/knn_cluster_scan.sv
// knn_cluster_scan -- nearest-neighbour scanner.
// Walks p_arr in chunks of CLSTR_SIZE points. Each SCAN cycle the lanes
// register one chunk of distances. The next cycle folds that chunk into a
// running best. The result is published with a one-cycle done pulse.
//
// Ports
//   clk, rst      clock, synchronous active-high reset
//   start         scan request, sampled only while idle
//   metric_sel    0 = squared Euclidean, 1 = Manhattan (captured on start)
//   q             query vector (captured on start)
//   p_arr         point array, held stable by the caller while busy
//   busy          scan in progress
//   done          one-cycle pulse, best_idx/best_dst valid
//   best_idx      index of the nearest point
//   best_dst      distance of the nearest point

// One distance lane: selects its point for the current chunk, computes the
// distance and registers distance/index/valid for the fold stage.
module knn_lane #(
    parameter int DIMENSION  = 3,
    parameter int SIZE       = 32,
    parameter int CLSTR_SIZE = 2,
    parameter int ARRAY_SIZE = 6,
    parameter int NCHUNK     = 3,
    parameter int CNT_W      = 2,
    parameter int IDX_W      = 3,
    parameter int DIST_W     = 67,
    parameter int LANE       = 0
) (
    input  logic                                        clk,
    input  logic                                        rst,
    input  logic                                        fire,
    input  logic                                        metric,
    input  logic [CNT_W-1:0]                            chunk,
    input  logic [DIMENSION-1:0][SIZE-1:0]              q,
    input  logic [ARRAY_SIZE-1:0][DIMENSION-1:0][SIZE-1:0] p_arr,
    output logic                                        ok,
    output logic [IDX_W-1:0]                            idx,
    output logic [DIST_W-1:0]                           dst
);
    // Per-chunk tables for this lane.
    // Indices past the end of the array become masked zero points.
    logic [NCHUNK-1:0][DIMENSION-1:0][SIZE-1:0] pts;
    logic [NCHUNK-1:0]                          ok_tab;
    logic [NCHUNK-1:0][IDX_W-1:0]               idx_tab;

    for (genvar c = 0; c < NCHUNK; c++) begin : g_chunk
        localparam int PI = c * CLSTR_SIZE + LANE;
        if (PI < ARRAY_SIZE) begin : g_real
            assign pts[c]    = p_arr[PI];
            assign ok_tab[c] = 1'b1;
        end else begin : g_mask
            assign pts[c]    = '0;
            assign ok_tab[c] = 1'b0;
        end
        assign idx_tab[c] = PI[IDX_W-1:0];
    end

    logic [DIST_W-1:0] sum;

    always_comb begin
        logic [DIMENSION-1:0][SIZE-1:0] pt;
        logic [SIZE-1:0]                diff;
        logic [2*SIZE-1:0]              dx;
        logic [2*SIZE-1:0]              sq;
        pt   = pts[chunk];
        sum  = '0;
        diff = '0;
        dx   = '0;
        sq   = '0;
        for (int d = 0; d < DIMENSION; d++) begin
            diff = (pt[d] >= q[d]) ? pt[d] - q[d] : q[d] - pt[d];
            dx   = {{SIZE{1'b0}}, diff};
            sq   = dx * dx;
            if (metric)
                sum = sum + {{(DIST_W-SIZE){1'b0}}, diff};
            else
                sum = sum + {{(DIST_W-2*SIZE){1'b0}}, sq};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ok  <= 1'b0;
            idx <= '0;
            dst <= '0;
        end else if (fire) begin
            ok  <= ok_tab[chunk];
            idx <= idx_tab[chunk];
            dst <= sum;
        end
    end
endmodule

module knn_cluster_scan #(
    parameter int DIMENSION  = 3,
    parameter int SIZE       = 32,
    parameter int CLSTR_SIZE = 2,
    parameter int ARRAY_SIZE = 6,
    localparam int DIST_W    = 2*SIZE + $clog2(DIMENSION) + 1,
    localparam int IDX_W     = (ARRAY_SIZE > 1) ? $clog2(ARRAY_SIZE) : 1
) (
    input  logic                                        clk,
    input  logic                                        rst,
    input  logic                                        start,
    input  logic                                        metric_sel,
    input  logic [DIMENSION-1:0][SIZE-1:0]              q,
    input  logic [ARRAY_SIZE-1:0][DIMENSION-1:0][SIZE-1:0] p_arr,
    output logic                                        busy,
    output logic                                        done,
    output logic [IDX_W-1:0]                            best_idx,
    output logic [DIST_W-1:0]                           best_dst
);
    localparam int NCHUNK = (ARRAY_SIZE + CLSTR_SIZE - 1) / CLSTR_SIZE;
    localparam int CNT_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(NCHUNK - 1);

    typedef enum logic [1:0] {IDLE, SCAN, FLUSH} state_t;
    state_t state, state_nxt;

    logic [CNT_W-1:0]               chunk;
    logic                           lane_vld;   // lane registers hold a chunk to fold
    logic [DIMENSION-1:0][SIZE-1:0] q_c;
    logic                           metric_c;
    logic [DIST_W-1:0]              run_dst;
    logic [IDX_W-1:0]               run_idx;

    logic [CLSTR_SIZE-1:0]             lane_ok;
    logic [CLSTR_SIZE-1:0][IDX_W-1:0]  lane_idx;
    logic [CLSTR_SIZE-1:0][DIST_W-1:0] lane_dst;

    for (genvar l = 0; l < CLSTR_SIZE; l++) begin : g_lane
        knn_lane #(
            .DIMENSION(DIMENSION), .SIZE(SIZE), .CLSTR_SIZE(CLSTR_SIZE),
            .ARRAY_SIZE(ARRAY_SIZE), .NCHUNK(NCHUNK), .CNT_W(CNT_W),
            .IDX_W(IDX_W), .DIST_W(DIST_W), .LANE(l)
        ) u_lane (
            .clk    (clk),
            .rst    (rst),
            .fire   (state == SCAN),
            .metric (metric_c),
            .chunk  (chunk),
            .q      (q_c),
            .p_arr  (p_arr),
            .ok     (lane_ok[l]),
            .idx    (lane_idx[l]),
            .dst    (lane_dst[l])
        );
    end

    // Ascending lane order with strict less-than means the lowest index
    // wins on a tie.
    logic [DIST_W-1:0] f_dst;
    logic [IDX_W-1:0]  f_idx;

    always_comb begin
        f_dst = run_dst;
        f_idx = run_idx;
        for (int l = 0; l < CLSTR_SIZE; l++) begin
            if (lane_ok[l] && (lane_dst[l] < f_dst)) begin
                f_dst = lane_dst[l];
                f_idx = lane_idx[l];
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = SCAN;
            SCAN:    if (chunk == LAST) state_nxt = FLUSH;
            FLUSH:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign busy = (state != IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            chunk    <= '0;
            lane_vld <= 1'b0;
            q_c      <= '0;
            metric_c <= 1'b0;
            run_dst  <= '0;
            run_idx  <= '0;
            done     <= 1'b0;
            best_idx <= '0;
            best_dst <= '0;
        end else begin
            state    <= state_nxt;
            done     <= 1'b0;
            lane_vld <= (state == SCAN);
            if (lane_vld) begin
                run_dst <= f_dst;
                run_idx <= f_idx;
            end
            case (state)
                IDLE: if (start) begin
                    q_c      <= q;
                    metric_c <= metric_sel;
                    // All-ones exceeds any real distance, so point 0 always replaces it.
                    run_dst  <= '1;
                    run_idx  <= '0;
                    chunk    <= '0;
                end
                SCAN:  chunk <= chunk + 1'b1;
                FLUSH: begin
                    best_dst <= f_dst;
                    best_idx <= f_idx;
                    done     <= 1'b1;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_knn_cluster_scan.sv
module tb_knn_cluster_scan;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic msel = 1'b0;
    logic [3:0] st = '0;
    logic [3:0] bsy, dn;

    logic [5:0][2:0][31:0] pa;
    logic [2:0][31:0]      qa;
    logic [4:0][2:0][31:0] pb;
    logic [2:0][31:0]      qb;
    logic [5:0][2:0][7:0]  pc;
    logic [2:0][7:0]       qc;
    logic [2:0]  idx0, idx1, idx2, idx3;
    logic [66:0] dst0, dst1, dst2;
    logic [18:0] dst3;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    knn_cluster_scan dut (
        .clk(clk), .rst(rst), .start(st[0]), .metric_sel(msel), .q(qa), .p_arr(pa),
        .busy(bsy[0]), .done(dn[0]), .best_idx(idx0), .best_dst(dst0));
    knn_cluster_scan #(.ARRAY_SIZE(5), .CLSTR_SIZE(2)) dut_a5c2 (
        .clk(clk), .rst(rst), .start(st[1]), .metric_sel(msel), .q(qb), .p_arr(pb),
        .busy(bsy[1]), .done(dn[1]), .best_idx(idx1), .best_dst(dst1));
    knn_cluster_scan #(.ARRAY_SIZE(5), .CLSTR_SIZE(1)) dut_a5c1 (
        .clk(clk), .rst(rst), .start(st[2]), .metric_sel(msel), .q(qb), .p_arr(pb),
        .busy(bsy[2]), .done(dn[2]), .best_idx(idx2), .best_dst(dst2));
    knn_cluster_scan #(.SIZE(8)) dut_s8 (
        .clk(clk), .rst(rst), .start(st[3]), .metric_sel(msel), .q(qc), .p_arr(pc),
        .busy(bsy[3]), .done(dn[3]), .best_idx(idx3), .best_dst(dst3));

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic setpa(input int i, input int x, input int y, input int z);
        pa[i][0] = x;
        pa[i][1] = y;
        pa[i][2] = z;
    endtask

    task automatic fill_pa(input int v);
        for (int i = 0; i < 6; i++) setpa(i, v, v, v);
    endtask

    task automatic load_t1();
        qa = {32'd10, 32'd10, 32'd10};
        setpa(0, 0, 0, 0);     setpa(1, 10, 10, 12);   setpa(2, 9, 11, 10);
        setpa(3, 100, 100, 100); setpa(4, 10, 10, 10); setpa(5, 50, 0, 0);
    endtask

    // Pulse start on unit u; return edges from the start-sampling edge to done.
    // Returns at the negedge of the done cycle.
    task automatic scan(input int u, input logic m, output int lat);
        @(negedge clk);
        msel = m;
        st[u] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        st[u] = 1'b0;
        chk("busy_after_start", 128'(bsy[u]), 128'(1));
        lat = 0;
        while (lat < 40) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (dn[u]) break;
        end
    endtask

    initial begin
        int lat;
        int cnt;
        pa = '0; pb = '0; pc = '0; qa = '0; qb = '0; qc = '0;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", 128'(bsy), 128'(0));
        chk("rst_done", 128'(dn), 128'(0));
        chk("rst_idx", 128'(idx0), 128'(0));
        chk("rst_dst", 128'(dst0), 128'(0));
        rst = 1'b0;

        // 1: basic scan, exact match at index 4
        load_t1();
        scan(0, 1'b0, lat);
        chk("t1_lat", 128'(lat), 128'(4));
        chk("t1_busy_done_cycle", 128'(bsy[0]), 128'(0));
        chk("t1_idx", 128'(idx0), 128'(4));
        chk("t1_dst", 128'(dst0), 128'(0));
        qa = '0;
        @(negedge clk);
        chk("t1_done_clears", 128'(dn[0]), 128'(0));
        repeat (3) @(negedge clk);
        chk("t1_hold_idx", 128'(idx0), 128'(4));
        chk("t1_hold_dst", 128'(dst0), 128'(0));

        // 2: ties resolve to the lowest index
        qa = {32'd10, 32'd10, 32'd10};
        fill_pa(0);
        setpa(1, 11, 10, 10); setpa(3, 10, 9, 10);
        scan(0, 1'b0, lat);
        chk("t2_idx", 128'(idx0), 128'(1));
        chk("t2_dst", 128'(dst0), 128'(1));
        setpa(1, 10, 9, 10); setpa(3, 11, 10, 10);
        scan(0, 1'b0, lat);
        chk("t2_swap_idx", 128'(idx0), 128'(1));
        chk("t2_swap_dst", 128'(dst0), 128'(1));

        // 3: metric selection changes the winner
        qa = '0;
        fill_pa(50);
        setpa(0, 2, 0, 0); setpa(1, 1, 1, 1);
        scan(0, 1'b0, lat);
        chk("t3_m0_idx", 128'(idx0), 128'(1));
        chk("t3_m0_dst", 128'(dst0), 128'(3));
        scan(0, 1'b1, lat);
        chk("t3_m1_idx", 128'(idx0), 128'(0));
        chk("t3_m1_dst", 128'(dst0), 128'(2));

        // 4: ARRAY_SIZE=5 with a partial last chunk
        qb = '0;
        for (int i = 0; i < 4; i++) pb[i] = {32'd1, 32'd1, 32'd1};
        pb[4] = '0;
        scan(1, 1'b0, lat);
        chk("t4_c2_lat", 128'(lat), 128'(4));
        chk("t4_c2_idx", 128'(idx1), 128'(4));
        chk("t4_c2_dst", 128'(dst1), 128'(0));
        scan(2, 1'b0, lat);
        chk("t4_c1_lat", 128'(lat), 128'(6));
        chk("t4_c1_idx", 128'(idx2), 128'(4));
        chk("t4_c1_dst", 128'(dst2), 128'(0));
        // A masked lane would look like a zero-distance point and must not win.
        pb[4] = {32'd1, 32'd1, 32'd1};
        scan(1, 1'b0, lat);
        chk("t4_mask_idx", 128'(idx1), 128'(0));
        chk("t4_mask_dst", 128'(dst1), 128'(3));

        // 5: SIZE=8 full-range coordinates, no wrap
        qc = '0;
        for (int i = 0; i < 6; i++) pc[i] = {8'd255, 8'd255, 8'd255};
        pc[5][2] = 8'd254;
        scan(3, 1'b0, lat);
        chk("t5_lat", 128'(lat), 128'(4));
        chk("t5_m0_idx", 128'(idx3), 128'(5));
        chk("t5_m0_dst", 128'(dst3), 128'(194566));
        scan(3, 1'b1, lat);
        chk("t5_m1_idx", 128'(idx3), 128'(5));
        chk("t5_m1_dst", 128'(dst3), 128'(764));

        // 6a: start held while busy gives exactly one done
        load_t1();
        cnt = 0;
        @(negedge clk);
        msel = 1'b0;
        st[0] = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (i == 3) st[0] = 1'b0;
            if (dn[0]) cnt++;
        end
        chk("t6_held_done_count", 128'(cnt), 128'(1));
        chk("t6_held_idx", 128'(idx0), 128'(4));

        // 6b: start during the done cycle runs back-to-back
        qa = '0;
        fill_pa(50);
        setpa(0, 2, 0, 0); setpa(1, 1, 1, 1);
        scan(0, 1'b0, lat);
        chk("t6_b2b_first_idx", 128'(idx0), 128'(1));
        msel = 1'b1;
        st[0] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        st[0] = 1'b0;
        chk("t6_b2b_busy", 128'(bsy[0]), 128'(1));
        lat = 0;
        while (lat < 40) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (dn[0]) break;
        end
        chk("t6_b2b_lat", 128'(lat), 128'(4));
        chk("t6_b2b_idx", 128'(idx0), 128'(0));
        chk("t6_b2b_dst", 128'(dst0), 128'(2));

        // 6c: reset mid-scan abandons the scan
        qa = {32'd10, 32'd10, 32'd10};
        fill_pa(0);
        setpa(1, 11, 10, 10); setpa(3, 10, 9, 10);
        scan(0, 1'b0, lat);
        chk("t6_pre_rst_idx", 128'(idx0), 128'(1));
        @(negedge clk);
        st[0] = 1'b1;
        @(posedge clk);            // E0
        @(negedge clk);
        st[0] = 1'b0;
        @(posedge clk);            // E1
        @(negedge clk);
        rst = 1'b1;
        st[0] = 1'b1;
        @(posedge clk);            // E2
        @(negedge clk);
        rst = 1'b0;
        st[0] = 1'b0;
        chk("t6_rst_busy", 128'(bsy[0]), 128'(0));
        chk("t6_rst_done", 128'(dn[0]), 128'(0));
        chk("t6_rst_idx", 128'(idx0), 128'(0));
        chk("t6_rst_dst", 128'(dst0), 128'(0));
        cnt = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (dn[0]) cnt++;
        end
        chk("t6_rst_no_done", 128'(cnt), 128'(0));

        // 6d: fresh start after reset
        load_t1();
        scan(0, 1'b0, lat);
        chk("t6_fresh_lat", 128'(lat), 128'(4));
        chk("t6_fresh_idx", 128'(idx0), 128'(4));
        chk("t6_fresh_dst", 128'(dst0), 128'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/knn_cluster_scan.md
Name: knn_cluster_scan

Overview:
- Nearest-neighbour scanner for the KNN datapath: finds the single point in a point array closest to a query vector.
- Processes CLSTR_SIZE points per clock in a two-stage pipeline (lane distance, then fold into a running best).
- Supports squared-Euclidean or Manhattan metric, selected at run time; reports best index and distance with a start/busy/done handshake.
- Generalises the fixed sliding-window distance cluster: arbitrary ARRAY_SIZE, masked partial last chunk, metric mode, deterministic tie-break.

Parameters:
DIMENSION, 3, coordinates per point
SIZE, 32, bits per unsigned coordinate
CLSTR_SIZE, 2, distance lanes evaluated per cycle (>=1)
ARRAY_SIZE, 6, points in p_arr (>=1; need not be a multiple of CLSTR_SIZE)
DIST_W, 2*SIZE+$clog2(DIMENSION)+1, distance width (derived; do not override)
IDX_W, max(1,$clog2(ARRAY_SIZE)), index width (derived)

Ports:
clk  input  1  clock, all logic on rising edge
rst  input  1  synchronous active-high reset
start  input  1  request a scan; sampled only when busy=0
metric_sel  input  1  0 = squared Euclidean, 1 = Manhattan; captured on accepted start
q  input  SIZE x DIMENSION  query; captured on accepted start
p_arr  input  SIZE x DIMENSION x ARRAY_SIZE  points; caller holds stable while busy=1
busy  output  1  scan in progress
done  output  1  one-cycle pulse, results valid
best_idx  output  IDX_W  index of nearest point
best_dst  output  DIST_W  distance of nearest point

Behaviour:
- Reset (rst=1 at an edge): busy=0, done=0, best_idx=0, best_dst=0, chunk counter=0, pipeline valid bits=0, FSM=IDLE. Applies mid-scan: the scan is abandoned and no done is produced. A start in the same cycle as rst is ignored.
- N = ceil(ARRAY_SIZE/CLSTR_SIZE) chunks. Chunk c covers indices c*CLSTR_SIZE+l for lane l. Lanes with index >= ARRAY_SIZE are masked and never update the best.
- Per-coordinate term: diff = |p-q| as unsigned SIZE bits.
  - Metric 0: sum of diff^2.
  - Metric 1: sum of diff.
  - Both zero-extended to DIST_W, with no overflow or saturation.
- FSM states IDLE, SCAN, FLUSH:
  - IDLE: busy=0. start=1 at edge E0 captures q and metric_sel, clears the running best to {dst=all-ones, idx=0}, and moves to SCAN. busy=1 from E0.
  - SCAN: at edges E1..EN, lane registers capture the chunk 0..N-1 distances and valid masks. At EN, move to FLUSH.
  - FLUSH: at edge E(N+1), the last chunk folds in. best_idx and best_dst load the final values, done=1, busy=0, FSM=IDLE.
- Fold (edges E2..E(N+1)): each valid lane, in ascending lane order, replaces the running best only if its distance is strictly less than the best. The lowest index therefore wins ties.
- Latency: done is high during the cycle after E(N+1), i.e. N+1 edges after the start-sampling edge. done is cleared at the next edge.
- Outputs best_idx and best_dst change only at the done edge; they hold between scans.
- start while busy=1 is ignored; there is no queueing.
- start=1 during the done cycle is accepted, giving a back-to-back scan with no idle cycle.
- p_arr changes while busy=1 are undefined behaviour. The q and metric_sel inputs may change freely after capture.
- The all-ones initial best guarantees point 0 (always valid) replaces it, since the maximum real distance is less than 2^DIST_W-1.

Test Plan:
1. Defaults; q=(10,10,10); p0..p5=(0,0,0),(10,10,12),(9,11,10),(100,100,100),(10,10,10),(50,0,0); metric 0; start one cycle -> busy for 4 edges; done pulses once after edge E4 with best_idx=4, best_dst=0; outputs hold afterwards.
2. Tie: q=(10,10,10); p1=(11,10,10), p3=(10,9,10), all others (0,0,0) -> best_idx=1, best_dst=1. Swap p1 and p3 contents -> best_idx=1 again (strict-less, lowest index).
3. Metric: q=(0,0,0); p0=(2,0,0), p1=(1,1,1), others (50,50,50) -> metric 0 gives idx=1, dst=3; metric 1 gives idx=0, dst=2.
4. Partial chunk, ARRAY_SIZE=5, CLSTR_SIZE=2: q=0; p0..p3=(1,1,1), p4=(0,0,0) -> done after 4 edges; idx=4, dst=0; the masked lane never wins. Repeat with CLSTR_SIZE=1 -> done after 6 edges, same result.
5. Width, SIZE=8: q=0, all points (255,255,255) except p5=(255,255,254) -> metric 0 gives idx=5, dst=194566; metric 1 gives idx=5, dst=764. No wrap.
6. Control:
   - start held high while busy -> exactly one done per scan.
   - start during the done cycle -> second done 4 edges later.
   - rst asserted at edge E2 with start=1 -> busy=0, done never pulses, outputs 0.
   - A fresh start after reset -> correct result.
